// File: rtl/avg_pkg.sv
// Shared types and width helpers for the streaming averager.
//   clog2     : ceiling log2 of a positive integer (clog2(1) == 0)
//   sum_width : width of the raw batch sum for a WIDTH/LANES/DEPTH configuration
//   state_e   : batch sequencing states
package avg_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      OUT   = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int sum_width(input int width, input int lanes, input int depth);
      return width + clog2(lanes * depth);
   endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered binary adder tree with a valid sideband.
// Ports:
//   clk_sys  in   clock, rising edge
//   rst_b    in   asynchronous reset, active-low (clears data and valid)
//   flush_i  in   synchronous flush of all valid bits in flight
//   valid_i  in   input beat valid
//   data_i   in   LANES samples of WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   valid_o  out  valid of the summed beat leaving the tree
//   data_o   out  sum of all lanes, WIDTH+clog2(LANES) bits
// Level 0 is the raw input; each later level is a register stage that halves
// the lane count and grows the word by one bit, so nothing is ever truncated.
// With LANES == 1 there are no stages and the input passes straight through.
module adder_tree_pipe
   import avg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 8
) (
   input  logic                               clk_sys,
   input  logic                               rst_b,
   input  logic                               flush_i,
   input  logic                               valid_i,
   input  logic [LANES*WIDTH-1:0]             data_i,
   output logic                               valid_o,
   output logic [WIDTH+clog2(LANES)-1:0]      data_o
);

   localparam int TL = clog2(LANES);

   for (genvar s = 0; s <= TL; s++) begin : g_lvl
      localparam int NS = LANES >> s;
      localparam int SW = WIDTH + s;
      logic [NS*SW-1:0] lvl_data;
      logic             lvl_vld;

      if (s == 0) begin : g_src
         assign lvl_data = data_i;
         assign lvl_vld  = valid_i;
      end else begin : g_stage
         localparam int PW = SW - 1;
         logic [NS*SW-1:0] lvl_data_d;

         always_comb begin
            lvl_data_d = '0;
            for (int k = 0; k < NS; k++) begin
               lvl_data_d[k*SW +: SW] = SW'(g_lvl[s-1].lvl_data[(2*k)*PW +: PW])
                                      + SW'(g_lvl[s-1].lvl_data[(2*k+1)*PW +: PW]);
            end
         end

         always_ff @(posedge clk_sys or negedge rst_b) begin
            if (!rst_b) begin
               lvl_data <= '0;
               lvl_vld  <= 1'b0;
            end else begin
               lvl_data <= lvl_data_d;
               lvl_vld  <= flush_i ? 1'b0 : g_lvl[s-1].lvl_vld;
            end
         end
      end
   end

   assign data_o  = g_lvl[TL].lvl_data;
   assign valid_o = g_lvl[TL].lvl_vld;

endmodule

// File: rtl/avg_stream_param.sv
// Streaming averager: accepts LANES samples per beat, sums DEPTH beats and
// presents the batch sum and its rounded (ROUND=1) or truncated average.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   clr        in   synchronous abort of the current batch
//   in_valid   in   / in_ready out / in_data in : sample beat handshake
//   out_valid  out  / out_ready in               : result handshake
//   avg        out  batch average, WIDTH bits
//   sum        out  raw batch sum, WIDTH+clog2(LANES*DEPTH) bits
//
// state | meaning
// ACCUM | accepting beats, counting towards DEPTH
// DRAIN | input closed, waiting for the last beat to reach the accumulator
// OUT   | result held on avg/sum until the consumer takes it
module avg_stream_param
   import avg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 8,
   parameter int DEPTH = 32,
   parameter int ROUND = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       clr,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [LANES*WIDTH-1:0]                     in_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [WIDTH-1:0]                           avg,
   output logic [sum_width(WIDTH, LANES, DEPTH)-1:0]  sum
);

   localparam int N     = LANES * DEPTH;
   localparam int S     = clog2(N);
   localparam int TL    = clog2(LANES);
   localparam int SUM_W = sum_width(WIDTH, LANES, DEPTH);
   localparam int TW    = WIDTH + TL;
   localparam int BW    = clog2(DEPTH);
   localparam int DC_W  = clog2(TL + 2) + 1;
   localparam int HALF  = (ROUND != 0) ? (1 << (S - 1)) : 0;

   state_e            state_q;
   logic [BW-1:0]     beat_cnt_q;
   logic [SUM_W-1:0]  acc_q;
   logic [SUM_W-1:0]  sum_q;
   logic [DC_W-1:0]   drain_cnt_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  avg_q;

   logic              beat_acc;
   logic              tree_vld;
   logic [TW-1:0]     tree_data;
   logic [SUM_W:0]    rnd;
   logic              unused_rnd;

   assign in_ready = (state_q == ACCUM);
   assign beat_acc = in_valid & in_ready;

   adder_tree_pipe #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_tree (
      .clk_sys (clk),
      .rst_b   (rst),
      .flush_i (clr),
      .valid_i (beat_acc),
      .data_i  (in_data),
      .valid_o (tree_vld),
      .data_o  (tree_data)
   );

   // One spare bit absorbs the rounding carry; the quotient always fits WIDTH.
   assign rnd        = {1'b0, acc_q} + (SUM_W + 1)'(HALF);
   assign unused_rnd = ^{rnd[SUM_W], rnd[S-1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACCUM;
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         drain_cnt_q <= '0;
         out_valid_q <= 1'b0;
         avg_q       <= '0;
         sum_q       <= '0;
      end else if (clr) begin
         state_q     <= ACCUM;
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         drain_cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (tree_vld) acc_q <= acc_q + SUM_W'(tree_data);
         case (state_q)
            ACCUM: begin
               if (beat_acc) begin
                  beat_cnt_q <= beat_cnt_q + BW'(1);
                  if (&beat_cnt_q) begin
                     state_q     <= DRAIN;
                     // last beat needs TL tree stages plus one accumulate edge
                     drain_cnt_q <= DC_W'(TL + 1);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) begin
                  state_q     <= OUT;
                  sum_q       <= acc_q;
                  avg_q       <= rnd[S +: WIDTH];
                  out_valid_q <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - DC_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  acc_q       <= '0;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign avg       = avg_q;
   assign sum       = sum_q;

endmodule

// File: tb/tb_avg_stream_param.sv
module tb_avg_stream_param;

   logic        clk;
   logic        rst, clr, in_valid, out_ready;
   logic [63:0] in_data;
   logic        in_ready, out_valid, in_ready_t, out_valid_t;
   logic [7:0]  avg, avg_t;
   logic [15:0] sum, sum_t;

   logic        rst1, clr1, in_valid1, out_ready1, in_ready1, out_valid1;
   logic [7:0]  in_data1, avg1;
   logic [9:0]  sum1;

   int n_pass = 0;
   int n_total = 0;
   int last_avg, last_sum;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   avg_stream_param #(.WIDTH(8), .LANES(8), .DEPTH(32), .ROUND(1)) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .avg(avg), .sum(sum));

   avg_stream_param #(.WIDTH(8), .LANES(8), .DEPTH(32), .ROUND(0)) u_dut_t (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_t),
      .in_data(in_data), .out_valid(out_valid_t), .out_ready(out_ready), .avg(avg_t), .sum(sum_t));

   avg_stream_param #(.WIDTH(8), .LANES(1), .DEPTH(4), .ROUND(1)) u_dut_l1 (
      .clk(clk), .rst(rst1), .clr(clr1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .avg(avg1), .sum(sum1));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge after the beat was taken.
   task automatic put_beat(input logic [63:0] d);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_total++;
      if (t >= 100) $display("FAIL put_beat_ready_timeout: in_ready=%0b want 1", in_ready);
      else n_pass++;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
   endtask

   task automatic send_const(input logic [7:0] v, input int beats);
      for (int b = 0; b < beats; b++) put_beat({8{v}});
   endtask

   task automatic wait_out(output int k);
      k = 0;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_total++;
      if ({out_valid, in_ready, avg, sum} !== {1'b0, 1'b1, 8'd0, 16'd0})
         $display("FAIL reset_outputs: got v=%0b r=%0b avg=%0d sum=%0d want v=0 r=1 avg=0 sum=0",
                  out_valid, in_ready, avg, sum);
      else n_pass++;
      n_total++;
      if ({out_valid1, in_ready1, avg1, sum1} !== {1'b0, 1'b1, 8'd0, 10'd0})
         $display("FAIL reset_outputs_l1: got v=%0b r=%0b avg=%0d sum=%0d", out_valid1, in_ready1, avg1, sum1);
      else n_pass++;
   endtask

   task automatic test_const100();
      int k;
      send_const(8'd100, 32);
      wait_out(k);
      n_total++;
      if (k !== 5) $display("FAIL const100_latency: got %0d want 5", k); else n_pass++;
      n_total++;
      if (sum !== 16'd25600) $display("FAIL const100_sum: got %0d want 25600", sum); else n_pass++;
      n_total++;
      if (avg !== 8'd100) $display("FAIL const100_avg: got %0d want 100", avg); else n_pass++;
      handshake();
      n_total++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL const100_after_hs: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_round();
      int k;
      put_beat(64'd128);
      send_const(8'd0, 31);
      wait_out(k);
      n_total++;
      if ({sum, sum_t} !== {16'd128, 16'd128}) $display("FAIL round_sum: got %0d/%0d want 128/128", sum, sum_t);
      else n_pass++;
      n_total++;
      if (avg !== 8'd1) $display("FAIL round_avg_round: got %0d want 1", avg); else n_pass++;
      n_total++;
      if (avg_t !== 8'd0) $display("FAIL round_avg_trunc: got %0d want 0", avg_t); else n_pass++;
      handshake();
   endtask

   task automatic test_full();
      int k;
      send_const(8'd255, 32);
      wait_out(k);
      n_total++;
      if (sum !== 16'd65280) $display("FAIL full_sum: got %0d want 65280", sum); else n_pass++;
      n_total++;
      if ({avg, avg_t} !== {8'd255, 8'd255}) $display("FAIL full_avg: got %0d/%0d want 255/255", avg, avg_t);
      else n_pass++;
      handshake();
   endtask

   task automatic test_random();
      int k, exp_sum;
      logic [63:0] d;
      exp_sum = 0;
      for (int b = 0; b < 32; b++) begin
         if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
         end
         for (int l = 0; l < 8; l++) d[l*8 +: 8] = 8'($urandom_range(0, 255));
         for (int l = 0; l < 8; l++) exp_sum += int'(d[l*8 +: 8]);
         put_beat(d);
      end
      wait_out(k);
      n_total++;
      if (k !== 5) $display("FAIL random_latency: got %0d want 5", k); else n_pass++;
      n_total++;
      if (sum !== 16'(exp_sum)) $display("FAIL random_sum: got %0d want %0d", sum, exp_sum); else n_pass++;
      n_total++;
      if (avg !== 8'((exp_sum + 128) >> 8)) $display("FAIL random_avg: got %0d want %0d", avg, (exp_sum + 128) >> 8);
      else n_pass++;
      n_total++;
      if (avg_t !== 8'(exp_sum >> 8)) $display("FAIL random_avg_trunc: got %0d want %0d", avg_t, exp_sum >> 8);
      else n_pass++;
      handshake();
   endtask

   task automatic test_backpressure();
      int k;
      send_const(8'd20, 32);
      wait_out(k);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++;
         if ({out_valid, in_ready, avg, sum} !== {1'b1, 1'b0, 8'd20, 16'd5120})
            $display("FAIL backpressure_hold: cycle %0d got v=%0b r=%0b avg=%0d sum=%0d want v=1 r=0 avg=20 sum=5120",
                     i, out_valid, in_ready, avg, sum);
         else n_pass++;
      end
      // next batch's first beat is already offered during the handshake cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = {8{8'd40}};
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL backpressure_after_hs: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
      else n_pass++;
      send_const(8'd40, 32);
      wait_out(k);
      n_total++;
      if (k !== 5) $display("FAIL b2b_latency: got %0d want 5", k); else n_pass++;
      n_total++;
      if ({avg, sum} !== {8'd40, 16'd10240}) $display("FAIL b2b_result: got avg=%0d sum=%0d want 40/10240", avg, sum);
      else n_pass++;
      handshake();
      last_avg = 40;
      last_sum = 10240;
   endtask

   task automatic test_clr();
      int k;
      send_const(8'd9, 17);
      in_valid = 1'b1;
      in_data  = {8{8'd9}};
      clr      = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, in_ready, avg, sum} !== {1'b0, 1'b1, 8'(last_avg), 16'(last_sum)})
         $display("FAIL clr_state: got v=%0b r=%0b avg=%0d sum=%0d want v=0 r=1 avg=%0d sum=%0d",
                  out_valid, in_ready, avg, sum, last_avg, last_sum);
      else n_pass++;
      send_const(8'd50, 32);
      wait_out(k);
      n_total++;
      if (k !== 5) $display("FAIL clr_latency: got %0d want 5", k); else n_pass++;
      n_total++;
      if ({avg, sum} !== {8'd50, 16'd12800}) $display("FAIL clr_result: got avg=%0d sum=%0d want 50/12800", avg, sum);
      else n_pass++;
      handshake();
   endtask

   task automatic test_rst_drain();
      int k, seen;
      send_const(8'd3, 32);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_total++;
      if ({out_valid, in_ready, avg, sum} !== {1'b0, 1'b1, 8'd0, 16'd0})
         $display("FAIL rst_drain_async: got v=%0b r=%0b avg=%0d sum=%0d want v=0 r=1 avg=0 sum=0",
                  out_valid, in_ready, avg, sum);
      else n_pass++;
      #1 rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_total++;
      if (seen !== 0) $display("FAIL rst_drain_no_result: out_valid seen %0d cycles want 0", seen); else n_pass++;
      send_const(8'd7, 32);
      wait_out(k);
      n_total++;
      if ({avg, sum} !== {8'd7, 16'd1792}) $display("FAIL rst_followup: got avg=%0d sum=%0d want 7/1792", avg, sum);
      else n_pass++;
      handshake();
   endtask

   task automatic put_beat1(input logic [7:0] d);
      int t;
      t = 0;
      while (!in_ready1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_total++;
      if (t >= 100) $display("FAIL put_beat1_ready_timeout: in_ready1=%0b want 1", in_ready1);
      else n_pass++;
      in_valid1 = 1'b1;
      in_data1  = d;
      @(negedge clk);
      in_valid1 = 1'b0;
      in_data1  = 8'($urandom);
   endtask

   task automatic test_lanes1();
      int k, seen;
      logic [7:0] vals [4];
      vals = '{8'd1, 8'd2, 8'd3, 8'd5};
      for (int b = 0; b < 4; b++) put_beat1(8'd9);
      #2 rst1 = 1'b0;
      #1;
      n_total++;
      if ({out_valid1, in_ready1, sum1} !== {1'b0, 1'b1, 10'd0})
         $display("FAIL l1_rst_async: got v=%0b r=%0b sum=%0d want v=0 r=1 sum=0", out_valid1, in_ready1, sum1);
      else n_pass++;
      #1 rst1 = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid1) seen++;
      end
      n_total++;
      if (seen !== 0) $display("FAIL l1_no_result: out_valid1 seen %0d cycles want 0", seen); else n_pass++;
      for (int b = 0; b < 4; b++) put_beat1(vals[b]);
      k = 0;
      while (!out_valid1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (k !== 2) $display("FAIL l1_latency: got %0d want 2", k); else n_pass++;
      n_total++;
      if ({avg1, sum1} !== {8'd3, 10'd11}) $display("FAIL l1_result: got avg=%0d sum=%0d want 3/11", avg1, sum1);
      else n_pass++;
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      n_total++;
      if ({out_valid1, in_ready1} !== 2'b01)
         $display("FAIL l1_after_hs: got v=%0b r=%0b want v=0 r=1", out_valid1, in_ready1);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      rst1 = 1'b0; clr1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
      last_avg = 0;
      last_sum = 0;
      repeat (3) @(negedge clk);
      test_reset();
      rst  = 1'b1;
      rst1 = 1'b1;
      @(negedge clk);
      test_const100();
      test_round();
      test_full();
      test_random();
      test_random();
      test_backpressure();
      test_clr();
      test_rst_drain();
      test_lanes1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
